eth_intr_ctrl: RTL and testbench
================================

# eth_intr_ctrl

Interrupt source block for the Ethernet MAC. It latches single-cycle event pulses from the TX/RX datapaths into a sticky status register and gates them with a mask. An optional coalescing engine, driven by an event-count threshold and a timeout, decides when to raise the level interrupt `intr`. `intr` and `rst` are the signals the testbench interrupt interface monitors. Software services the block through a small register port with write-1-to-clear status.

## Interface
- `NUM_SRC`, 7, number of event sources. Bit order: TXB, TXE, RXB, RXE, BUSY, TXC, RXC.
- `CNT_W`, 8, width of the coalescing threshold and the event counter.
- `TMO_W`, 16, width of the coalescing timeout and the timer.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `src_pulse`  in  NUM_SRC  one-cycle event pulses; several bits may be set in the same cycle.
- `reg_wr`  in  1  register write strobe.
- `reg_rd`  in  1  register read strobe.
- `reg_addr`  in  2  register select: 0 = INT_SOURCE, 1 = INT_MASK, 2 = COAL_CFG, 3 = COAL_STAT (read-only).
- `reg_wdata`  in  32  write data.
- `reg_rdata`  out  32  read data, registered.
- `intr`  out  1  level interrupt to the host, registered.

## Operation
- INT_SOURCE[NUM_SRC-1:0]:
  - Bit i sets on `src_pulse[i]`.
  - Bit i clears on a write to address 0 with `reg_wdata[i]=1`.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Writes to INT_SOURCE never set bits.
- INT_MASK[NUM_SRC-1:0]: read/write; 1 = enabled.
- COAL_CFG:
  - [CNT_W-1:0] = THRESH. A value of 0 or 1 disables coalescing.
  - [16+TMO_W-1:16] = TIMEOUT in clk cycles. A value of 0 disables the timer.
- COAL_STAT:
  - [1:0] = state encoding: 0 = IDLE, 1 = ACCUM, 2 = ASSERT.
  - [15:8] = evt_cnt.
  - [31:16] = timer.
- Unused register bits read 0. Writes to address 3 are ignored.
- `pending = |(INT_SOURCE & INT_MASK)`.
- `mevt` = any bit of `src_pulse & INT_MASK` in the current cycle. Each such cycle counts as one event, regardless of how many bits are set.
- State machine:
  - IDLE, on `mevt`:
    - THRESH ≤ 1: go to ASSERT.
    - Otherwise: go to ACCUM with evt_cnt=1 and timer=0.
  - ACCUM:
    - Each cycle: timer += 1, saturating.
    - On `mevt`: evt_cnt += 1, saturating at 2^CNT_W-1.
    - Go to ASSERT when evt_cnt (including the current `mevt`) ≥ THRESH, or when TIMEOUT≠0 and timer+1 ≥ TIMEOUT.
    - Go to IDLE if `pending` is 0 and there is no `mevt` this cycle.
  - ASSERT:
    - Go to IDLE when `pending` is 0. This follows W1C or masking.
    - evt_cnt and timer are cleared on entering IDLE.
- Unmasking a bit that is already set while in IDLE counts as a `mevt` in that cycle.
- Config writes take effect from the next cycle. A threshold change in ACCUM is compared against the current evt_cnt.
- `intr` = (state == ASSERT), driven from a flop.

## Timing
- Reset values: all of the following are 0 — INT_SOURCE, INT_MASK, COAL_CFG, state (IDLE), evt_cnt, timer, `intr`, `reg_rdata`.
- Reset is sampled every edge. Asserting it mid-ACCUM or mid-ASSERT drops `intr` on the next edge.
- `src_pulse` at edge N: the status bit is visible at N+1.
- With coalescing off: `intr` is high from N+1.
- With THRESH=T: `intr` is high in the cycle after the edge that samples the T-th masked event.
- Timeout: with the first masked event at edge N, `intr` rises after edge N+TIMEOUT.
- The W1C that clears the last pending bit is sampled at edge M. `intr` is low from M+1.
- `reg_rd` at edge N: `reg_rdata` is valid after N and holds until the next `reg_rd`.
- A simultaneous `reg_rd` and W1C to INT_SOURCE returns the pre-clear value.

## Test plan
- Reset then idle: all outputs 0. Then write MASK=0x7F, pulse `src_pulse`=0x04 → INT_SOURCE reads 0x04; `intr` rises 1 cycle after the pulse. Write 0x04 to addr 0 → `intr` low next cycle; INT_SOURCE reads 0.
- Masking: MASK=0x01, pulse 0x02 → INT_SOURCE=0x02, `intr` stays 0. Then write MASK=0x03 → `intr`=1 next cycle.
- Coalescing by count: THRESH=4, TIMEOUT=0, four masked pulses spaced 3 cycles apart → `intr` stays low through pulse 3 and rises after pulse 4; COAL_STAT shows ACCUM with evt_cnt=3 before pulse 4.
- Coalescing by time: THRESH=10, TIMEOUT=20, one masked pulse at cycle N → `intr` rises at N+20. A second pulse at N+5 does not restart the timer.
- Set/clear collision: W1C of bit 0 in the same cycle as `src_pulse[0]` → bit 0 stays 1 and `intr` stays 1. A multi-bit pulse 0x05 in one cycle → evt_cnt increments by 1.
- Reset mid-operation: in ASSERT with INT_SOURCE=0x7F, pull `rst_n` low for 1 cycle → `intr`=0, all registers 0 after that edge. A pulse during reset is not latched.

Source files
------------

// File: rtl/eth_intr_ctrl_if.sv
// ---------------------------------------------------------------------------
// eth_intr_ctrl_if
//   Bundles the event inputs, the software register port and the interrupt
//   output of eth_intr_ctrl.
//
//   src_pulse  : one-cycle event pulses from the TX/RX datapaths
//   reg_wr     : register write strobe
//   reg_rd     : register read strobe
//   reg_addr   : register select (0 SOURCE, 1 MASK, 2 COAL_CFG, 3 COAL_STAT)
//   reg_wdata  : write data
//   reg_rdata  : registered read data
//   intr       : registered level interrupt to the host
//
//   master : the side that drives events and register accesses
//   slave  : the interrupt controller
// ---------------------------------------------------------------------------
interface eth_intr_ctrl_if #(
    parameter int NUM_SRC = 7
);
    logic [NUM_SRC-1:0] src_pulse;
    logic               reg_wr;
    logic               reg_rd;
    logic [1:0]         reg_addr;
    logic [31:0]        reg_wdata;
    logic [31:0]        reg_rdata;
    logic               intr;

    modport master (
        output src_pulse, reg_wr, reg_rd, reg_addr, reg_wdata,
        input  reg_rdata, intr
    );

    modport slave (
        input  src_pulse, reg_wr, reg_rd, reg_addr, reg_wdata,
        output reg_rdata, intr
    );
endinterface

// File: rtl/eth_intr_ctrl.sv
// ---------------------------------------------------------------------------
// eth_intr_ctrl
//   Interrupt source block for the Ethernet MAC. Event pulses are latched in
//   a sticky status register (write-1-to-clear), gated with a mask, and an
//   optional coalescing engine (event-count threshold + timeout) decides when
//   the level interrupt is raised.
//
//   clk    : single clock, rising edge
//   rst_n  : synchronous, active-low reset
//   bus    : eth_intr_ctrl_if.slave (events, register port, intr)
//
//   Register map:
//     0 INT_SOURCE [NUM_SRC-1:0]  sticky status, W1C
//     1 INT_MASK   [NUM_SRC-1:0]  1 = enabled
//     2 COAL_CFG   [CNT_W-1:0] THRESH, [16+TMO_W-1:16] TIMEOUT
//     3 COAL_STAT  [1:0] state, [15:8] evt_cnt, [31:16] timer (read-only)
//   Layout assumes CNT_W <= 8 and TMO_W <= 16.
// ---------------------------------------------------------------------------
module eth_intr_ctrl #(
    parameter int NUM_SRC = 7,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    eth_intr_ctrl_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_ASSERT = 2'd2
    } state_t;

    // Register state
    logic [NUM_SRC-1:0] r_int_source;
    logic [NUM_SRC-1:0] r_int_mask;
    logic [CNT_W-1:0]   r_thresh;
    logic [TMO_W-1:0]   r_timeout;
    state_t             r_state;
    logic [CNT_W-1:0]   r_evt_cnt;
    logic [TMO_W-1:0]   r_timer;
    logic               r_intr;
    logic [31:0]        r_rdata;

    // Combinational next values
    logic [NUM_SRC-1:0] w_src_next;
    logic [NUM_SRC-1:0] w_mask_next;
    state_t             w_state_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [TMO_W-1:0]   w_timer_next;
    logic [31:0]        w_rdata_next;

    logic w_wr_src;
    logic w_wr_mask;
    logic w_wr_cfg;
    logic w_pending;
    logic w_mevt;
    logic w_unmask_evt;
    logic w_thresh_off;
    logic w_timeout_hit;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [TMO_W-1:0]   w_timer_inc;

    // Bits 15:8 of write data land in no register field.
    logic w_unused_wdata;
    assign w_unused_wdata = ^bus.reg_wdata;

    assign w_wr_src  = bus.reg_wr && (bus.reg_addr == 2'd0);
    assign w_wr_mask = bus.reg_wr && (bus.reg_addr == 2'd1);
    assign w_wr_cfg  = bus.reg_wr && (bus.reg_addr == 2'd2);

    // Sticky status: a pulse always wins over a same-cycle W1C of that bit.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign w_src_next[gi] = bus.src_pulse[gi]
                                  | (r_int_source[gi] & ~(w_wr_src & bus.reg_wdata[gi]));
        end
    endgenerate

    assign w_mask_next = w_wr_mask ? bus.reg_wdata[NUM_SRC-1:0] : r_int_mask;

    // Pending is judged on the post-edge status/mask so that a W1C or a
    // mask write sampled at edge M drops intr right after M.
    assign w_pending = |(w_src_next & w_mask_next);

    // Unmasking an already-latched source while idle behaves like a fresh event.
    assign w_unmask_evt = (r_state == ST_IDLE) && w_wr_mask
                        && |(r_int_source & bus.reg_wdata[NUM_SRC-1:0] & ~r_int_mask);

    // Each cycle with any masked pulse is one event, however many bits fire.
    assign w_mevt = (|(bus.src_pulse & r_int_mask)) || w_unmask_evt;

    assign w_thresh_off = (r_thresh <= CNT_W'(1));
    assign w_cnt_inc    = (r_evt_cnt == '1) ? r_evt_cnt : r_evt_cnt + CNT_W'(1);
    assign w_timer_inc  = (r_timer == '1)   ? r_timer   : r_timer + TMO_W'(1);
    assign w_timeout_hit = (r_timeout != '0)
                         && (({1'b0, r_timer} + (TMO_W+1)'(1)) >= {1'b0, r_timeout});

    // Next-state / counter logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_evt_cnt;
        w_timer_next = r_timer;
        case (r_state)
            ST_IDLE: begin
                if (w_mevt) begin
                    if (w_thresh_off) begin
                        w_state_next = ST_ASSERT;
                    end else begin
                        w_state_next = ST_ACCUM;
                        w_cnt_next   = CNT_W'(1);
                        w_timer_next = '0;
                    end
                end
            end
            ST_ACCUM: begin
                w_timer_next = w_timer_inc;
                if (w_mevt) begin
                    w_cnt_next = w_cnt_inc;
                end
                // A threshold lowered while accumulating is compared against
                // the running count, so >= rather than == is required here.
                if ((w_cnt_next >= r_thresh) || w_timeout_hit) begin
                    w_state_next = ST_ASSERT;
                end else if (!w_pending && !w_mevt) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                if (!w_pending) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if ((w_state_next == ST_IDLE) && (r_state != ST_IDLE)) begin
            w_cnt_next   = '0;
            w_timer_next = '0;
        end
    end

    // Read mux over pre-edge register values, so a read coinciding with a
    // W1C returns the status before the clear.
    always_comb begin
        w_rdata_next = '0;
        case (bus.reg_addr)
            2'd0: w_rdata_next[NUM_SRC-1:0] = r_int_source;
            2'd1: w_rdata_next[NUM_SRC-1:0] = r_int_mask;
            2'd2: begin
                w_rdata_next[CNT_W-1:0]   = r_thresh;
                w_rdata_next[16 +: TMO_W] = r_timeout;
            end
            default: begin
                w_rdata_next[1:0]         = r_state;
                w_rdata_next[8 +: CNT_W]  = r_evt_cnt;
                w_rdata_next[16 +: TMO_W] = r_timer;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_int_source <= '0;
            r_int_mask   <= '0;
            r_thresh     <= '0;
            r_timeout    <= '0;
            r_state      <= ST_IDLE;
            r_evt_cnt    <= '0;
            r_timer      <= '0;
            r_intr       <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_int_source <= w_src_next;
            r_int_mask   <= w_mask_next;
            if (w_wr_cfg) begin
                r_thresh  <= bus.reg_wdata[CNT_W-1:0];
                r_timeout <= bus.reg_wdata[16 +: TMO_W];
            end
            r_state   <= w_state_next;
            r_evt_cnt <= w_cnt_next;
            r_timer   <= w_timer_next;
            // intr registered from the next state so it tracks ASSERT with
            // no extra cycle of latency.
            r_intr    <= (w_state_next == ST_ASSERT);
            if (bus.reg_rd) begin
                r_rdata <= w_rdata_next;
            end
        end
    end

    assign bus.intr      = r_intr;
    assign bus.reg_rdata = r_rdata;

endmodule

// File: tb/tb_eth_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_eth_intr_ctrl
//   Directed self-checking bench for eth_intr_ctrl. Inputs are driven and
//   outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_eth_intr_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    eth_intr_ctrl_if #(.NUM_SRC(7)) bus();

    eth_intr_ctrl #(
        .NUM_SRC (7),
        .CNT_W   (8),
        .TMO_W   (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.reg_wr    = 1'b1;
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        step();
        bus.reg_wr    = 1'b0;
        $display("wr   addr=%0d data=0x%08h", a, d);
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.reg_rd   = 1'b1;
        bus.reg_addr = a;
        step();
        bus.reg_rd   = 1'b0;
        $display("rd   addr=%0d data=0x%08h", a, bus.reg_rdata);
        check_eq(tag, bus.reg_rdata, exp);
    endtask

    task automatic pulse(input logic [6:0] v);
        bus.src_pulse = v;
        step();
        bus.src_pulse = '0;
        $display("evt  src=0x%02h intr=%0b", v, bus.intr);
    endtask

    task automatic check_intr(input string tag, input logic exp);
        check_eq(tag, {31'b0, bus.intr}, {31'b0, exp});
    endtask

    // Hard stop in case something wedges the run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.src_pulse = '0;
        bus.reg_wr    = 1'b0;
        bus.reg_rd    = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;

        // Reset state
        idle(3);
        check_intr("rst_intr", 1'b0);
        check_eq("rst_rdata", bus.reg_rdata, 32'h0);
        rst_n = 1'b1;
        idle(2);
        check_intr("idle_intr", 1'b0);
        rd_check("rst_src",  2'd0, 32'h0);
        rd_check("rst_mask", 2'd1, 32'h0);
        rd_check("rst_cfg",  2'd2, 32'h0);
        rd_check("rst_stat", 2'd3, 32'h0);

        // Basic latch / interrupt / W1C, coalescing off
        wr(2'd1, 32'h7F);
        pulse(7'h04);
        check_intr("basic_intr_rise", 1'b1);
        rd_check("basic_src", 2'd0, 32'h04);
        wr(2'd0, 32'h04);
        check_intr("basic_intr_fall", 1'b0);
        rd_check("basic_src_clr", 2'd0, 32'h0);
        rd_check("basic_stat", 2'd3, 32'h0);

        // Masking, then unmasking an already latched source
        wr(2'd1, 32'h01);
        pulse(7'h02);
        check_intr("mask_intr_low", 1'b0);
        rd_check("mask_src", 2'd0, 32'h02);
        wr(2'd1, 32'h03);
        check_intr("unmask_intr", 1'b1);
        wr(2'd0, 32'h02);
        check_intr("unmask_clr", 1'b0);

        // Coalescing by count: THRESH=4, TIMEOUT=0
        wr(2'd2, 32'h0000_0004);
        pulse(7'h01);
        check_intr("cnt_p1", 1'b0);
        idle(2);
        pulse(7'h01);
        check_intr("cnt_p2", 1'b0);
        idle(2);
        pulse(7'h01);
        check_intr("cnt_p3", 1'b0);
        idle(1);
        // ACCUM, evt_cnt=3, timer=7 before the read edge
        rd_check("cnt_stat", 2'd3, 32'h0007_0301);
        check_intr("cnt_pre4", 1'b0);
        pulse(7'h01);
        check_intr("cnt_p4", 1'b1);
        wr(2'd0, 32'h7F);
        check_intr("cnt_clr", 1'b0);
        rd_check("cnt_stat_idle", 2'd3, 32'h0);

        // Coalescing by time: THRESH=10, TIMEOUT=20; second pulse at N+5
        wr(2'd2, 32'h0014_000A);
        pulse(7'h01);
        check_intr("tmo_start", 1'b0);
        idle(4);
        pulse(7'h01);
        idle(14);
        check_intr("tmo_n19", 1'b0);
        idle(1);
        check_intr("tmo_n20", 1'b1);
        wr(2'd0, 32'h7F);
        check_intr("tmo_clr", 1'b0);

        // Set/clear collision, coalescing off
        wr(2'd2, 32'h0);
        pulse(7'h01);
        check_intr("coll_rise", 1'b1);
        bus.src_pulse = 7'h01;
        bus.reg_wr    = 1'b1;
        bus.reg_addr  = 2'd0;
        bus.reg_wdata = 32'h01;
        step();
        bus.src_pulse = '0;
        bus.reg_wr    = 1'b0;
        $display("coll src=0x01 w1c=0x01 intr=%0b", bus.intr);
        check_intr("coll_intr", 1'b1);
        rd_check("coll_src", 2'd0, 32'h01);
        wr(2'd0, 32'h7F);
        check_intr("coll_clr", 1'b0);

        // Multi-bit pulse counts once; read with W1C returns pre-clear value
        wr(2'd1, 32'h7F);
        wr(2'd2, 32'h4);
        pulse(7'h05);
        rd_check("multi_stat1", 2'd3, 32'h0000_0101);
        pulse(7'h05);
        rd_check("multi_stat2", 2'd3, 32'h0002_0201);
        check_intr("multi_intr", 1'b0);
        bus.reg_rd    = 1'b1;
        bus.reg_wr    = 1'b1;
        bus.reg_addr  = 2'd0;
        bus.reg_wdata = 32'h7F;
        step();
        bus.reg_rd    = 1'b0;
        bus.reg_wr    = 1'b0;
        $display("rdwc addr=0 data=0x%08h", bus.reg_rdata);
        check_eq("rdw1c_preclear", bus.reg_rdata, 32'h05);
        rd_check("rdw1c_stat", 2'd3, 32'h0);

        // Reset mid-ASSERT with a pulse during reset
        wr(2'd2, 32'h0);
        pulse(7'h7F);
        check_intr("rstm_rise", 1'b1);
        rd_check("rstm_src", 2'd0, 32'h7F);
        rst_n         = 1'b0;
        bus.src_pulse = 7'h01;
        step();
        bus.src_pulse = '0;
        rst_n         = 1'b1;
        $display("rst  mid-assert intr=%0b", bus.intr);
        check_intr("rstm_intr", 1'b0);
        check_eq("rstm_rdata", bus.reg_rdata, 32'h0);
        rd_check("rstm_src0",  2'd0, 32'h0);
        rd_check("rstm_mask0", 2'd1, 32'h0);
        rd_check("rstm_cfg0",  2'd2, 32'h0);
        rd_check("rstm_stat0", 2'd3, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
